master_alu: RTL and testbench
=============================

Name: master_alu

Overview:
- Registered 32-bit integer ALU for the processor datapath, between the register file and the writeback/flag registers.
- Each cycle it:
  - evaluates a 4-bit condition code against the incoming NZCV flags;
  - executes one of 16 opcodes on two signed operands or a 16-bit immediate;
  - registers the result and the updated flag vector.

Parameters:
- WIDTH, 32, datapath width; all arithmetic and shift rules below assume 32.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- reg1  in  32  operand A, signed
- reg2  in  32  operand B, signed
- iv  in  16  immediate value
- opcode  in  4  operation select
- cond  in  4  condition code
- s  in  1  set-flags enable
- result  out  32  registered result, signed
- flag  in  4  current flags {N,Z,C,V}; bit3=N, bit2=Z, bit1=C, bit0=V
- new_flag  out  4  registered updated flags, same bit order as flag

Behaviour:
- Reset: rst_n low asynchronously forces result=0 and new_flag=4'b0000.
- Latency: 1 cycle. Inputs sampled at a rising edge appear on the outputs after that edge. No handshake; a new operation is accepted every cycle.
- Operand B: B = zero-extended iv when iv != 0, otherwise B = reg2.
- Condition codes (evaluated on the flag input):
  - 0000 AL, 0001 EQ (Z), 0010 NE (!Z), 0011 CS (C), 0100 CC (!C), 0101 MI (N), 0110 PL (!N), 0111 VS (V), 1000 VC (!V)
  - 1001 HI (C&!Z), 1010 LS (!C|Z), 1011 GE (N==V), 1100 LT (N!=V), 1101 GT (!Z&N==V), 1110 LE (Z|N!=V), 1111 NV (never)
- Condition false or opcode NOP: result holds its previous value; new_flag <= flag.
- Opcodes:
  - 0000 ADD: A+B
  - 0001 SUB: A-B
  - 0010 MUL: low 32 bits of the signed product
  - 0011 OR, 0100 AND, 0101 XOR: bitwise A op B
  - 0110 MOVN: ~B
  - 0111 MOV: B
  - 1000 LSR: A >> B[4:0], logical
  - 1001 LSL: A << B[4:0]
  - 1010 ROR: A rotated right by B[4:0]
  - 1011 CMP: result = A-B
  - 1100 ADR, 1101 LDR, 1110 STR: result = reg1 + sign-extended iv (address generation)
  - 1111 NOP
- Flag update occurs when (s=1 or opcode=CMP) and the condition passes; otherwise new_flag <= flag.
  - N = result[31]; Z = (result==0) for every flag-updating opcode.
  - ADD: C = carry out of bit 31; V = both operands share a sign and the result sign differs.
  - SUB/CMP: C = no borrow (A >= B unsigned); V = operand signs differ and result sign differs from A.
  - MUL: C unchanged; V = 64-bit signed product does not fit in 32 bits.
  - LSR/LSL: C = last bit shifted out; when the shift amount is 0, C is unchanged. V unchanged.
  - ROR: C = result[31] when the amount != 0, else unchanged. V unchanged.
  - Logic ops, MOV, MOVN, ADR, LDR, STR: C and V unchanged.
- Arithmetic wraps modulo 2^32 with no saturation.

Decomposition:
- Package master_alu_pkg holds:
  - opcode localparams (OP_ADD..OP_NOP);
  - condition localparams (CC_AL..CC_NV);
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, master_alu_cond_check: combinational; takes cond and flag, returns pass.
- Datapath and output registers stay in master_alu.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> result=0 and new_flag=0000 immediately, with no clock edge required.
- ADD overflow: reg1=0x60000000, reg2=0x20000001, iv=0, cond=0000, s=1, flag=0000 -> after one edge, result=0x80000001, new_flag=1001.
- SUB equal: reg1=7, reg2=7, opcode=0001, s=1 -> result=0, new_flag=0110.
- Conditional MUL:
  - 7*7, cond=EQ, flag=0000 -> result holds, new_flag=0000;
  - repeat with flag=0100 -> result=49, new_flag=0000.
- Logic/shift with s=1:
  - XOR 5^70 -> result=67, new_flag=0000;
  - ROR 5 by 70 (amount 6) -> result=0x14000000, new_flag=0000;
  - LSR 5 by 7 -> result=0, new_flag=0100.
- CMP with s=0: reg1=5, reg2=7 -> result=-2, new_flag=1000.
- s=0 ADD, flag=1111 -> result updates, new_flag=1111.
- NOP: result holds, new_flag tracks flag.
- ADR: reg1=5, iv=16'hFFFF -> result=4.

Source files
------------

// File: rtl/master_alu_pkg.sv
// master_alu_pkg: shared constants for the master_alu datapath.
//   - opcode encodings (OP_ADD .. OP_NOP)
//   - condition-code encodings (CC_AL .. CC_NV)
//   - bit positions of the {N,Z,C,V} flag vector
package master_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_MOVN = 4'b0110;
  localparam logic [3:0] OP_MOV  = 4'b0111;
  localparam logic [3:0] OP_LSR  = 4'b1000;
  localparam logic [3:0] OP_LSL  = 4'b1001;
  localparam logic [3:0] OP_ROR  = 4'b1010;
  localparam logic [3:0] OP_CMP  = 4'b1011;
  localparam logic [3:0] OP_ADR  = 4'b1100;
  localparam logic [3:0] OP_LDR  = 4'b1101;
  localparam logic [3:0] OP_STR  = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam logic [3:0] CC_AL = 4'b0000;
  localparam logic [3:0] CC_EQ = 4'b0001;
  localparam logic [3:0] CC_NE = 4'b0010;
  localparam logic [3:0] CC_CS = 4'b0011;
  localparam logic [3:0] CC_CC = 4'b0100;
  localparam logic [3:0] CC_MI = 4'b0101;
  localparam logic [3:0] CC_PL = 4'b0110;
  localparam logic [3:0] CC_VS = 4'b0111;
  localparam logic [3:0] CC_VC = 4'b1000;
  localparam logic [3:0] CC_HI = 4'b1001;
  localparam logic [3:0] CC_LS = 4'b1010;
  localparam logic [3:0] CC_GE = 4'b1011;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GT = 4'b1101;
  localparam logic [3:0] CC_LE = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/master_alu_cond_check.sv
// master_alu_cond_check: combinational condition-code evaluator.
// Ports:
//   i_cond [3:0] - condition code
//   i_flag [3:0] - current flags {N,Z,C,V}
//   o_pass       - 1 when the condition holds for i_flag
module master_alu_cond_check
  import master_alu_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flag,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flag[FLAG_N];
  assign w_z = i_flag[FLAG_Z];
  assign w_c = i_flag[FLAG_C];
  assign w_v = i_flag[FLAG_V];

  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      CC_AL: o_pass = 1'b1;
      CC_EQ: o_pass = w_z;
      CC_NE: o_pass = !w_z;
      CC_CS: o_pass = w_c;
      CC_CC: o_pass = !w_c;
      CC_MI: o_pass = w_n;
      CC_PL: o_pass = !w_n;
      CC_VS: o_pass = w_v;
      CC_VC: o_pass = !w_v;
      CC_HI: o_pass = w_c && !w_z;
      CC_LS: o_pass = !w_c || w_z;
      CC_GE: o_pass = (w_n == w_v);
      CC_LT: o_pass = (w_n != w_v);
      CC_GT: o_pass = !w_z && (w_n == w_v);
      CC_LE: o_pass = w_z || (w_n != w_v);
      CC_NV: o_pass = 1'b0;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/master_alu.sv
// master_alu: registered 32-bit integer ALU with conditional execution.
// Ports:
//   clk, rst_n     - clock (rising edge), asynchronous active-low reset
//   reg1, reg2     - signed operands A and B
//   iv             - 16-bit immediate; when non-zero it replaces reg2 as B
//   opcode, cond   - operation select and condition code
//   s              - set-flags enable (CMP always sets flags)
//   flag           - incoming flags {N,Z,C,V}
//   result         - registered result (holds when not executed)
//   new_flag       - registered updated flags
module master_alu
  import master_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] reg1,
  input  logic signed [WIDTH-1:0] reg2,
  input  logic        [15:0]      iv,
  input  logic        [3:0]       opcode,
  input  logic        [3:0]       cond,
  input  logic                    s,
  input  logic        [3:0]       flag,
  output logic signed [WIDTH-1:0] result,
  output logic        [3:0]       new_flag
);

  logic [31:0] r_result;
  logic [3:0]  r_flag;

  logic        w_pass;
  logic        w_exec;
  logic        w_set;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [4:0]  w_amt;
  logic [32:0] w_add;
  logic [32:0] w_sub;
  logic [63:0] w_prod;
  logic [32:0] w_lsl;
  logic [32:0] w_lsr;
  logic [63:0] w_rot;
  logic [31:0] w_res;
  logic        w_c;
  logic        w_v;

  master_alu_cond_check u_cond_check (
    .i_cond (cond),
    .i_flag (flag),
    .o_pass (w_pass)
  );

  assign w_a   = reg1;
  assign w_b   = (iv != 16'd0) ? {16'd0, iv} : reg2;
  assign w_amt = w_b[4:0];

  assign w_add  = {1'b0, w_a} + {1'b0, w_b};
  assign w_sub  = {1'b0, w_a} - {1'b0, w_b};
  // Sign-extending both operands to 64 bits makes the unsigned product's
  // low 64 bits equal to the full signed product.
  assign w_prod = {{32{w_a[31]}}, w_a} * {{32{w_b[31]}}, w_b};
  // Extra bit on each shifter catches the last bit shifted out.
  assign w_lsl  = {1'b0, w_a} << w_amt;
  assign w_lsr  = {w_a, 1'b0} >> w_amt;
  assign w_rot  = {w_a, w_a} >> w_amt;

  assign w_exec = w_pass && (opcode != OP_NOP);
  assign w_set  = w_exec && (s || (opcode == OP_CMP));

  always_comb begin
    w_res = r_result;
    w_c   = flag[FLAG_C];
    w_v   = flag[FLAG_V];
    case (opcode)
      OP_ADD: begin
        w_res = w_add[31:0];
        w_c   = w_add[32];
        w_v   = (w_a[31] == w_b[31]) && (w_add[31] != w_a[31]);
      end
      OP_SUB, OP_CMP: begin
        w_res = w_sub[31:0];
        w_c   = !w_sub[32];
        w_v   = (w_a[31] != w_b[31]) && (w_sub[31] != w_a[31]);
      end
      OP_MUL: begin
        w_res = w_prod[31:0];
        // Fits in 32 bits only if bits 63..31 are all equal.
        w_v   = !((&w_prod[63:31]) || !(|w_prod[63:31]));
      end
      OP_OR:   w_res = w_a | w_b;
      OP_AND:  w_res = w_a & w_b;
      OP_XOR:  w_res = w_a ^ w_b;
      OP_MOVN: w_res = ~w_b;
      OP_MOV:  w_res = w_b;
      OP_LSR: begin
        w_res = w_lsr[32:1];
        if (w_amt != 5'd0) w_c = w_lsr[0];
      end
      OP_LSL: begin
        w_res = w_lsl[31:0];
        if (w_amt != 5'd0) w_c = w_lsl[32];
      end
      OP_ROR: begin
        w_res = w_rot[31:0];
        if (w_amt != 5'd0) w_c = w_rot[31];
      end
      OP_ADR, OP_LDR, OP_STR: w_res = w_a + {{16{iv[15]}}, iv};
      default: w_res = r_result;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flag   <= 4'b0000;
    end else begin
      if (w_exec) r_result <= w_res;
      if (w_set) begin
        r_flag[FLAG_N] <= w_res[31];
        r_flag[FLAG_Z] <= (w_res == 32'd0);
        r_flag[FLAG_C] <= w_c;
        r_flag[FLAG_V] <= w_v;
      end else begin
        r_flag <= flag;
      end
    end
  end

  assign result   = r_result;
  assign new_flag = r_flag;

endmodule

// File: tb/tb_master_alu.sv
module tb_master_alu;

  logic               clk;
  logic               rst_n;
  logic signed [31:0] reg1;
  logic signed [31:0] reg2;
  logic [15:0]        iv;
  logic [3:0]         opcode;
  logic [3:0]         cond;
  logic               s;
  logic [3:0]         flag;
  logic signed [31:0] result;
  logic [3:0]         new_flag;

  int total = 0;
  int bad   = 0;

  master_alu #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .reg1     (reg1),
    .reg2     (reg2),
    .iv       (iv),
    .opcode   (opcode),
    .cond     (cond),
    .s        (s),
    .result   (result),
    .flag     (flag),
    .new_flag (new_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [3:0] cc,
                     input logic sf, input logic [31:0] a, input logic [31:0] b,
                     input logic [15:0] imm, input logic [3:0] fl,
                     input logic [31:0] er, input logic [3:0] ef);
    @(negedge clk);
    opcode = op; cond = cc; s = sf; reg1 = a; reg2 = b; iv = imm; flag = fl;
    @(posedge clk);
    #1;
    $display("txn %-10s op=%b cc=%b s=%b a=%h b=%h iv=%h fl=%b -> result=%h new_flag=%b",
             tag, op, cc, sf, a, b, imm, fl, result, new_flag);
    chk({tag, ".res"}, result, er);
    chk({tag, ".flg"}, {28'd0, new_flag}, {28'd0, ef});
  endtask

  initial begin
    rst_n = 1'b0; reg1 = '0; reg2 = '0; iv = '0; opcode = 4'b1111; cond = 4'b0000;
    s = 1'b0; flag = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.res", result, 32'd0);
    chk("rst.flg", {28'd0, new_flag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //   tag          op       cc       s     reg1          reg2          iv        flag     result        new_flag
    run("add_ovf",   4'b0000, 4'b0000, 1'b1, 32'h60000000, 32'h20000001, 16'h0000, 4'b0000, 32'h80000001, 4'b1001);
    run("sub_eq",    4'b0001, 4'b0000, 1'b1, 32'd7,        32'd7,        16'h0000, 4'b0000, 32'd0,        4'b0110);
    run("mul_skip",  4'b0010, 4'b0001, 1'b1, 32'd7,        32'd7,        16'h0000, 4'b0000, 32'd0,        4'b0000);
    run("mul_eq",    4'b0010, 4'b0001, 1'b1, 32'd7,        32'd7,        16'h0000, 4'b0100, 32'd49,       4'b0000);
    run("xor",       4'b0101, 4'b0000, 1'b1, 32'd5,        32'd70,       16'h0000, 4'b0000, 32'd67,       4'b0000);
    run("ror6",      4'b1010, 4'b0000, 1'b1, 32'd5,        32'd70,       16'h0000, 4'b0000, 32'h14000000, 4'b0000);
    run("lsr7",      4'b1000, 4'b0000, 1'b1, 32'd5,        32'd7,        16'h0000, 4'b0000, 32'd0,        4'b0100);
    run("cmp_s0",    4'b1011, 4'b0000, 1'b0, 32'd5,        32'd7,        16'h0000, 4'b0000, 32'hFFFFFFFE, 4'b1000);
    run("add_s0",    4'b0000, 4'b0000, 1'b0, 32'd1,        32'd2,        16'h0000, 4'b1111, 32'd3,        4'b1111);
    run("nop",       4'b1111, 4'b0000, 1'b1, 32'd9,        32'd9,        16'h0000, 4'b1010, 32'd3,        4'b1010);
    run("adr",       4'b1100, 4'b0000, 1'b0, 32'd5,        32'd0,        16'hFFFF, 4'b0000, 32'd4,        4'b0000);
    run("lsl1",      4'b1001, 4'b0000, 1'b1, 32'h80000001, 32'd1,        16'h0000, 4'b0000, 32'd2,        4'b0010);
    run("lsl0",      4'b1001, 4'b0000, 1'b1, 32'd3,        32'd0,        16'h0000, 4'b0011, 32'd3,        4'b0011);
    run("nv",        4'b0000, 4'b1111, 1'b1, 32'd100,      32'd100,      16'h0000, 4'b0101, 32'd3,        4'b0101);
    run("add_imm",   4'b0000, 4'b0000, 1'b1, 32'd1,        32'd100,      16'h8000, 4'b0000, 32'h00008001, 4'b0000);
    run("mul_ovf",   4'b0010, 4'b0000, 1'b1, 32'h00010000, 32'h00010000, 16'h0000, 4'b0010, 32'd0,        4'b0111);
    run("mov_gt",    4'b0111, 4'b1101, 1'b1, 32'd0,        32'hDEADBEEF, 16'h0000, 4'b1001, 32'hDEADBEEF, 4'b1001);
    run("add_lt",    4'b0000, 4'b1100, 1'b1, 32'd1,        32'd1,        16'h0000, 4'b1001, 32'hDEADBEEF, 4'b1001);
    run("movn",      4'b0110, 4'b0000, 1'b1, 32'd0,        32'd0,        16'h0000, 4'b0000, 32'hFFFFFFFF, 4'b1000);
    run("sub_vflow", 4'b0001, 4'b0000, 1'b1, 32'h80000000, 32'd1,        16'h0000, 4'b0000, 32'h7FFFFFFF, 4'b0011);

    // Asynchronous reset between clock edges, while an op is still applied.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.res", result, 32'd0);
    chk("arst.flg", {28'd0, new_flag}, 32'd0);
    @(posedge clk);
    #1;
    chk("arst_hold.res", result, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
